apb2_cmd_master: RTL and testbench
==================================

Name: apb2_cmd_master

Overview:
APB2 initiator that turns a simple valid/ready command stream into APB2 transfers toward peripherals such as the BLDC controller. It lets non-CPU logic (a UART command decoder or a bench) access peripheral registers without the EMPU. One outstanding transfer at a time. Each transfer's result comes back on a valid/ready response channel.

Parameters:
ADDR_WIDTH, 8, width of req_addr/paddr.
DATA_WIDTH, 32, width of write/read data; must be a multiple of 8.
PPROT_VALUE, 3'b000, constant driven on pprot.
TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort; only used with the optional feature; must be ≥1.

Ports:
pclk  in  1  APB clock; sole clock of the block.
preset_n  in  1  asynchronous active-low reset.
req_valid  in  1  command valid.
req_ready  out  1  command accepted when req_valid && req_ready.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  target address.
req_wdata  in  DATA_WIDTH  write data.
req_strb  in  DATA_WIDTH/8  write byte strobes.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
rsp_err  out  1  pslverr sampled, or timeout.
rsp_timeout  out  1  transfer aborted by timeout.
psel  out  1  APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction.
paddr  out  ADDR_WIDTH  APB address.
pwdata  out  DATA_WIDTH  APB write data.
pstrb  out  DATA_WIDTH/8  APB strobes.
pprot  out  3  APB protection, = PPROT_VALUE.
prdata  in  DATA_WIDTH  APB read data.
pready  in  1  APB ready.
pslverr  in  1  APB slave error.

Behaviour:
- Single clock pclk, asynchronous active-low reset preset_n. All outputs are registered except req_ready, which is decoded from state.
- Reset values: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, timeout counter=0.
- pprot is driven to PPROT_VALUE at all times.
- FSM states and transitions:
  - IDLE: req_ready=1. On accept, latch addr, write, wdata and strb into paddr/pwrite/pwdata/pstrb. Strobes are forced to 0 for reads. Next state SETUP.
  - SETUP: psel=1, penable=0; lasts exactly one cycle; next state ACCESS.
  - ACCESS: psel=1, penable=1. paddr, pwrite, pwdata and pstrb are held stable. On pready=1:
    - capture prdata for reads (0 for writes) into rsp_rdata;
    - capture pslverr into rsp_err;
    - rsp_timeout=0;
    - drop psel/penable;
    - next state RESP with rsp_valid=1.
  - RESP: rsp_valid=1 and rsp_* held stable until rsp_ready=1, then rsp_valid=0 and next state IDLE.
- req_ready=0 in SETUP, ACCESS and RESP. A request is never accepted in the same cycle a response is consumed.
- Latency with accept at cycle 0 and zero-wait slave: SETUP at 1, ACCESS at 2, rsp_valid at 3. With rsp_ready held high, the next accept occurs at cycle 4.
- Wait states: each cycle of pready=0 in ACCESS adds one cycle of latency.
- pready and pslverr are ignored outside ACCESS.
- Reset asserted mid-transfer: immediate return to reset values. Any pending response is discarded.

Optional Feature:
Macro APB_MASTER_TIMEOUT_EN.
- Defined:
  - An ACCESS-cycle counter clears on entering SETUP and increments every ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES with pready still 0, the transfer aborts: psel/penable drop, rsp_rdata=0, rsp_err=1, rsp_timeout=1, next state RESP.
  - pready=1 on the same cycle the limit is reached wins; the transfer completes normally.
- Not defined: no counter is built, ACCESS waits for pready indefinitely, and rsp_timeout is tied to 0.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, pready=1 immediately → SETUP then ACCESS one cycle each with stable paddr/pwdata; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read addr 0x04, slave inserts 3 wait states, prdata=0x12345678 → penable high for 4 cycles; pstrb=0; rsp_rdata=0x12345678 at cycle 6.
- Read with pslverr=1 on the pready cycle → rsp_err=1, rsp_timeout=0.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 → rsp_* stable, req_ready=0, no new psel; after rsp_ready, the next accept comes the cycle after.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready stuck 0 → psel drops after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- preset_n pulsed low during ACCESS → all outputs return to reset values asynchronously; the next request after release runs a normal transfer.

Source files
------------

// File: rtl/apb2_cmd_master_if.sv
// Bundle of the command/response stream and the APB2 bus for apb2_cmd_master.
// master: the initiator's view. slave: the view of whatever sits on the far
// side (command source, response sink and APB peripheral together).
interface apb2_cmd_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_strb;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [2:0]                pprot;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/apb2_cmd_master.sv
// apb2_cmd_master: turns a valid/ready command stream into single APB2
// transfers (one outstanding) and returns each result on a valid/ready
// response channel.
// Optional build macro APB_MASTER_TIMEOUT_EN: abort an ACCESS phase that has
// waited TIMEOUT_CYCLES cycles without pready; otherwise ACCESS waits forever.
module apb2_cmd_master #(
  parameter int         ADDR_WIDTH     = 8,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [2:0] PPROT_VALUE    = 3'b000,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input logic                 pclk,
  input logic                 preset_n,
  apb2_cmd_master_if.master   bus
);
  localparam int STRB_W = DATA_WIDTH / 8;

  // Elaboration-time guard on parameter legality.
  if ((DATA_WIDTH % 8 != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
    $error("apb2_cmd_master: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
  logic [STRB_W-1:0]     r_pstrb, w_pstrb_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic                  r_rsp_timeout, w_rsp_timeout_nxt;
  logic                  w_accept;
  logic                  w_timeout_hit;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Count stalled ACCESS cycles; the count restarts with every new transfer.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_timeout_hit = 1'b0;
    if (w_accept) begin
      w_cnt_nxt = '0;
    end else if ((r_state == S_ACCESS) && !bus.pready) begin
      w_cnt_nxt     = w_cnt_inc;
      w_timeout_hit = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    end
  end

  // Wait-state counter register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_cnt <= '0;
    else           r_cnt <= w_cnt_nxt;
  end
`else
  assign w_timeout_hit = 1'b0;
`endif

  // Next state and next value of every registered output.
  always_comb begin
    w_state_nxt       = r_state;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_pstrb_nxt       = r_pstrb;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_paddr_nxt  = bus.req_addr;
          w_pwrite_nxt = bus.req_write;
          w_pwdata_nxt = bus.req_wdata;
          // Reads never carry byte strobes onto the bus.
          w_pstrb_nxt  = bus.req_write ? bus.req_strb : '0;
          w_psel_nxt   = 1'b1;
          w_state_nxt  = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        // A completing slave beats the timeout when both land together.
        if (bus.pready) begin
          w_rsp_rdata_nxt   = r_pwrite ? '0 : bus.prdata;
          w_rsp_err_nxt     = bus.pslverr;
          w_rsp_timeout_nxt = 1'b0;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = S_RESP;
        end else if (w_timeout_hit) begin
          w_rsp_rdata_nxt   = '0;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Registered APB and response outputs.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_pstrb       <= w_pstrb_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.pstrb       = r_pstrb;
  assign bus.pprot       = PPROT_VALUE;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb2_cmd_master.sv
// Directed testbench for apb2_cmd_master. Inputs change and outputs are
// sampled on the falling edge of pclk; "cycle N" counts from the accept cycle.
module tb_apb2_cmd_master;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic pclk;
  logic preset_n;
  int   n_chk;
  int   n_err;
  int   pen_cnt;

  apb2_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb2_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PPROT_VALUE(3'b101), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n), .bus(bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  // Present one command in the current cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] s);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_strb  = s;
    chk("accept_ready", bus.req_ready, 1'b1);
    step();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_strb = '0;    bus.rsp_ready = 1'b0;
    bus.prdata = '0;      bus.pready = 1'b0;    bus.pslverr = 1'b0;
    preset_n = 1'b0;
    repeat (2) step();

    // Reset state
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_pwrite", bus.pwrite, 1'b0);
    chk("rst_paddr", bus.paddr, 8'h00);
    chk("rst_pwdata", bus.pwdata, 32'h0);
    chk("rst_pstrb", bus.pstrb, 4'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("pprot", bus.pprot, 3'b101);
    preset_n = 1'b1;
    step();

    // Zero-wait write
    bus.prdata = 32'hCAFEF00D; bus.pready = 1'b1; bus.rsp_ready = 1'b1;
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    chk("wr_setup_psel", bus.psel, 1'b1);
    chk("wr_setup_penable", bus.penable, 1'b0);
    chk("wr_setup_paddr", bus.paddr, 8'h10);
    chk("wr_setup_pwdata", bus.pwdata, 32'hDEADBEEF);
    chk("wr_setup_pstrb", bus.pstrb, 4'hF);
    chk("wr_setup_pwrite", bus.pwrite, 1'b1);
    chk("wr_setup_req_ready", bus.req_ready, 1'b0);
    step();
    chk("wr_access_psel", bus.psel, 1'b1);
    chk("wr_access_penable", bus.penable, 1'b1);
    chk("wr_access_paddr", bus.paddr, 8'h10);
    chk("wr_access_pwdata", bus.pwdata, 32'hDEADBEEF);
    step();
    chk("wr_rsp_valid", bus.rsp_valid, 1'b1);
    chk("wr_rsp_err", bus.rsp_err, 1'b0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("wr_rsp_psel", bus.psel, 1'b0);
    chk("wr_rsp_penable", bus.penable, 1'b0);
    step();
    chk("wr_done_rsp_valid", bus.rsp_valid, 1'b0);
    chk("wr_done_req_ready", bus.req_ready, 1'b1);

    // Read with three wait states
    bus.pready = 1'b0; bus.prdata = 32'h0;
    issue(1'b0, 8'h04, 32'hFFFFFFFF, 4'hF);
    chk("rd_setup_pstrb", bus.pstrb, 4'h0);
    chk("rd_setup_pwrite", bus.pwrite, 1'b0);
    chk("rd_setup_penable", bus.penable, 1'b0);
    pen_cnt = 0;
    for (int i = 2; i <= 5; i++) begin
      step();
      if (bus.penable === 1'b1) pen_cnt++;
      chk("rd_wait_rsp_valid", bus.rsp_valid, 1'b0);
      if (i == 5) begin
        bus.pready = 1'b1; bus.prdata = 32'h12345678;
      end
    end
    chk("rd_penable_cycles", pen_cnt, 4);
    step();
    bus.pready = 1'b0; bus.prdata = 32'h0;
    chk("rd_rsp_valid_c6", bus.rsp_valid, 1'b1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'h12345678);
    chk("rd_rsp_err", bus.rsp_err, 1'b0);
    step();

    // Slave error followed by response backpressure
    bus.rsp_ready = 1'b0; bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 32'hA5A5A5A5;
    issue(1'b0, 8'h08, 32'h0, 4'h0);
    step();
    chk("err_access_penable", bus.penable, 1'b1);
    step();
    chk("err_rsp_valid", bus.rsp_valid, 1'b1);
    chk("err_rsp_err", bus.rsp_err, 1'b1);
    chk("err_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("err_rsp_rdata", bus.rsp_rdata, 32'hA5A5A5A5);
    bus.pslverr = 1'b0; bus.pready = 1'b0; bus.prdata = 32'h0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h20;
    bus.req_wdata = 32'h11223344; bus.req_strb = 4'h3;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_err", bus.rsp_err, 1'b1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'hA5A5A5A5);
      chk("bp_req_ready", bus.req_ready, 1'b0);
      chk("bp_psel", bus.psel, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_release_rsp_valid", bus.rsp_valid, 1'b0);
    chk("bp_release_req_ready", bus.req_ready, 1'b1);
    chk("bp_release_psel", bus.psel, 1'b0);
    step();
    bus.req_valid = 1'b0; bus.pready = 1'b1;
    chk("bp_next_psel", bus.psel, 1'b1);
    chk("bp_next_penable", bus.penable, 1'b0);
    chk("bp_next_paddr", bus.paddr, 8'h20);
    chk("bp_next_pstrb", bus.pstrb, 4'h3);
    chk("bp_next_pwdata", bus.pwdata, 32'h11223344);
    step();
    step();
    chk("bp_next_rsp_valid", bus.rsp_valid, 1'b1);
    chk("bp_next_rsp_err", bus.rsp_err, 1'b0);
    chk("bp_next_rsp_rdata", bus.rsp_rdata, 32'h0);
    step();

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck slave: abort after TO ACCESS cycles
    bus.pready = 1'b0; bus.prdata = 32'hDEAD0001;
    issue(1'b0, 8'h30, 32'h0, 4'h0);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("to_access_penable", bus.penable, 1'b1);
      chk("to_access_psel", bus.psel, 1'b1);
    end
    step();
    chk("to_psel", bus.psel, 1'b0);
    chk("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk("to_rsp_err", bus.rsp_err, 1'b1);
    chk("to_rsp_timeout", bus.rsp_timeout, 1'b1);
    chk("to_rsp_rdata", bus.rsp_rdata, 32'h0);
    step();
    // pready on the limit cycle completes normally
    issue(1'b0, 8'h34, 32'h0, 4'h0);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("tw_access_penable", bus.penable, 1'b1);
      if (i == 5) begin
        bus.pready = 1'b1; bus.prdata = 32'h000055AA;
      end
    end
    step();
    bus.pready = 1'b0;
    chk("tw_rsp_valid", bus.rsp_valid, 1'b1);
    chk("tw_rsp_err", bus.rsp_err, 1'b0);
    chk("tw_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("tw_rsp_rdata", bus.rsp_rdata, 32'h000055AA);
    step();
`else
    // Long stall completes normally when no timeout is built
    bus.pready = 1'b0; bus.prdata = 32'h0;
    issue(1'b0, 8'h30, 32'h0, 4'h0);
    for (int i = 2; i <= 7; i++) begin
      step();
      chk("nt_access_penable", bus.penable, 1'b1);
      chk("nt_access_rsp_valid", bus.rsp_valid, 1'b0);
      if (i == 7) begin
        bus.pready = 1'b1; bus.prdata = 32'h0F0F0F0F;
      end
    end
    step();
    bus.pready = 1'b0;
    chk("nt_rsp_valid", bus.rsp_valid, 1'b1);
    chk("nt_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("nt_rsp_err", bus.rsp_err, 1'b0);
    chk("nt_rsp_rdata", bus.rsp_rdata, 32'h0F0F0F0F);
    step();
`endif

    // Asynchronous reset during ACCESS
    bus.pready = 1'b0;
    issue(1'b1, 8'h40, 32'h87654321, 4'hF);
    step();
    chk("ar_access_penable", bus.penable, 1'b1);
    #2 preset_n = 1'b0;
    #1;
    chk("ar_psel", bus.psel, 1'b0);
    chk("ar_penable", bus.penable, 1'b0);
    chk("ar_paddr", bus.paddr, 8'h00);
    chk("ar_pwdata", bus.pwdata, 32'h0);
    chk("ar_pstrb", bus.pstrb, 4'h0);
    chk("ar_pwrite", bus.pwrite, 1'b0);
    chk("ar_rsp_valid", bus.rsp_valid, 1'b0);
    chk("ar_req_ready", bus.req_ready, 1'b1);
    step();
    preset_n = 1'b1;
    step();
    bus.pready = 1'b1; bus.prdata = 32'h0BADCAFE;
    issue(1'b0, 8'h44, 32'h0, 4'h0);
    chk("ar_next_psel", bus.psel, 1'b1);
    chk("ar_next_paddr", bus.paddr, 8'h44);
    step();
    step();
    chk("ar_next_rsp_valid", bus.rsp_valid, 1'b1);
    chk("ar_next_rsp_rdata", bus.rsp_rdata, 32'h0BADCAFE);
    chk("ar_next_rsp_err", bus.rsp_err, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
